// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ req/ack requesters onto one APB bus.
// Optional ACCESS wait limit is built when APB_TIMEOUT_EN is defined.
module apb_rr_master #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             ack,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity check.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("apb_rr_master: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

    logic [NUM_REQ-1:0]     elig;
    logic                   hit_hi, hit_any;
    logic [PTR_W-1:0]       sel_hi, sel_lo, sel_idx;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    // Lowest eligible index at/above the pointer wins; otherwise wrap to lowest overall.
    always_comb begin : rr_pick
        elig    = req & ~ack_q;
        hit_hi  = 1'b0;
        hit_any = 1'b0;
        sel_hi  = '0;
        sel_lo  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (elig[j]) begin
                hit_any = 1'b1;
                sel_lo  = PTR_W'(j);
                if (PTR_W'(j) >= ptr_q) begin
                    hit_hi = 1'b1;
                    sel_hi = PTR_W'(j);
                end
            end
        end
        sel_idx = hit_hi ? sel_hi : sel_lo;
    end

    always_comb begin : rr_mux
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sel_idx == PTR_W'(j)) begin
                sel_write = req_write[j];
                sel_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (hit_any) begin
                    grant_d  = sel_idx;
                    pwrite_d = sel_write;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = NUM_REQ'(1) << grant_q;
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    err_d     = PSLVERR;
                    ptr_d     = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    state_d   = ST_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                // Stuck slave: abort with an error ack once the wait limit is hit.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    ack_d     = NUM_REQ'(1) << grant_q;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    ptr_d     = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin : regs
        if (PRESET) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign ack       = ack_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: directed scenarios plus randomized
// round-robin traffic checked against a queue-level arbitration model.
module tb_apb_rr_master;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     ack;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    apb_rr_master #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: pending requests, their payloads, RR pointer, last acked.
    logic        m_pend [NR];
    logic        m_wr   [NR];
    logic [31:0] m_ad   [NR];
    logic [31:0] m_wd   [NR];
    int          m_ptr;
    int          m_last;

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic wr, input logic [31:0] ad, input logic [31:0] wd);
        req_write[i]        = wr;
        req_addr[i*AW +: AW]  = ad;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic new_req(input int i);
        m_pend[i] = 1'b1;
        m_wr[i]   = 1'($urandom_range(0, 1));
        m_ad[i]   = $urandom & ~32'h3;
        m_wd[i]   = $urandom;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NR; i++) begin
            req[i] = m_pend[i];
            set_slot(i, m_wr[i], m_ad[i], m_wd[i]);
        end
    endtask

    // Next grant: first pending requester at or after the pointer, skipping the
    // one acked in the previous cycle if anybody else is waiting.
    function automatic int pick();
        for (int k = 0; k < NR; k++) begin
            int idx = (m_ptr + k) % NR;
            if (m_pend[idx] && idx != m_last) return idx;
        end
        for (int k = 0; k < NR; k++) begin
            int idx = (m_ptr + k) % NR;
            if (m_pend[idx]) return idx;
        end
        return -1;
    endfunction

    // Acts as the APB slave until an ack arrives; PREADY rises after nwait ACCESS cycles.
    task automatic complete(input int gidx, input int nwait, input logic [31:0] rd,
                            input logic er, input logic wr, input logic [31:0] ad,
                            input logic [31:0] wd, input string tag,
                            output int en_cnt, output logic [NR-1:0] ackv,
                            output logic [31:0] rdv, output logic erv, output logic bus_ok);
        logic done;
        logic scrambled;
        done = 1'b0; scrambled = 1'b0; en_cnt = 0; bus_ok = 1'b1;
        ackv = '0; rdv = '0; erv = 1'b0;
        cyc();
        for (int c = 0; c < 300; c++) begin
            if (ack !== '0) begin
                ackv = ack; rdv = rsp_rdata; erv = rsp_err; done = 1'b1;
                break;
            end
            if (PSEL === 1'b1) begin
                if (PADDR !== ad || PWRITE !== wr || PWDATA !== wd) bus_ok = 1'b0;
                if (!scrambled && gidx >= 0) begin
                    req_addr[gidx*AW +: AW]  = $urandom;
                    req_wdata[gidx*DW +: DW] = $urandom;
                    req_write[gidx]          = ~req_write[gidx];
                    scrambled = 1'b1;
                end
            end
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                en_cnt++;
                PREADY = (en_cnt > nwait);
            end else begin
                PREADY = 1'($urandom_range(0, 1));
            end
            if (PREADY && PSEL === 1'b1 && PENABLE === 1'b1) begin
                PRDATA = rd; PSLVERR = er;
            end else begin
                PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
            end
            cyc();
        end
        chk({tag, "_ack_arrived"}, done, 1'b1);
    endtask

    task automatic xfer_check(input int g, input int nwait, input logic [31:0] rd,
                              input logic er, input logic wr, input logic [31:0] ad,
                              input logic [31:0] wd, input string tag);
        int          en_cnt;
        logic [NR-1:0] ackv, exp_ack;
        logic [31:0] rdv;
        logic        erv, bus_ok;
        complete(g, nwait, rd, er, wr, ad, wd, tag, en_cnt, ackv, rdv, erv, bus_ok);
        exp_ack = '0;
        exp_ack[g] = 1'b1;
        chk({tag, "_ack"}, ackv, exp_ack);
        chk({tag, "_enable_cycles"}, en_cnt, nwait + 1);
        chk({tag, "_rdata"}, rdv, wr ? 32'h0 : rd);
        chk({tag, "_err"}, erv, er);
        chk({tag, "_bus_fields"}, bus_ok, 1'b1);
    endtask

    initial begin
        int           g, cnt, nw;
        logic [31:0]  rd;
        logic         er, any, ackseen;
        int           en_cnt;
        logic [NR-1:0] ackv;
        logic [31:0]  rdv;
        logic         erv, bus_ok;

        PRESET = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        cyc(); cyc();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_ack", ack, 2'b00);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", rsp_err, 1'b0);
        PRESET = 1'b0;
        cyc();

        // Zero-wait write from requester 0.
        set_slot(0, 1'b1, 32'h10, 32'hA5A50001);
        PRDATA = 32'h12345678; PREADY = 1'b1; PSLVERR = 1'b0;
        req = 2'b01;
        chk("w0_psel_before", PSEL, 1'b0);
        cyc();
        chk("w0_setup_psel", PSEL, 1'b1);
        chk("w0_setup_penable", PENABLE, 1'b0);
        chk("w0_setup_paddr", PADDR, 32'h10);
        chk("w0_setup_pwrite", PWRITE, 1'b1);
        chk("w0_setup_pwdata", PWDATA, 32'hA5A50001);
        cyc();
        chk("w0_access_psel", PSEL, 1'b1);
        chk("w0_access_penable", PENABLE, 1'b1);
        chk("w0_access_paddr", PADDR, 32'h10);
        chk("w0_access_noack", ack, 2'b00);
        cyc();
        chk("w0_ack", ack, 2'b01);
        chk("w0_err", rsp_err, 1'b0);
        chk("w0_rdata_zero", rsp_rdata, 32'h0);
        chk("w0_idle_psel", PSEL, 1'b0);
        chk("w0_idle_paddr_held", PADDR, 32'h10);
        req = 2'b00;

        // Read with two wait states from requester 1.
        set_slot(1, 1'b0, 32'h24, 32'h55);
        req = 2'b10;
        xfer_check(1, 2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h24, 32'h55, "rd1w2");
        req = 2'b00;

        // Both requesters held from reset: grants alternate every 3 cycles.
        PRESET = 1'b1; req = 2'b11; PREADY = 1'b1; PSLVERR = 1'b0;
        set_slot(0, 1'b1, 32'h100, 32'h1);
        set_slot(1, 1'b1, 32'h200, 32'h2);
        cyc();
        PRESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                cyc();
                cnt++;
            end while (ack === 2'b00 && cnt < 20);
            chk($sformatf("arb_ack_%0d", k), ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("arb_cycles_%0d", k), cnt, 3);
        end
        req = 2'b00;

        // Slave error then a clean transfer.
        set_slot(0, 1'b0, 32'h30, 32'h0);
        req = 2'b01;
        xfer_check(0, 0, 32'h0BAD0BAD, 1'b1, 1'b0, 32'h30, 32'h0, "slverr");
        set_slot(1, 1'b1, 32'h34, 32'hCAFEF00D);
        req = 2'b10;
        xfer_check(1, 1, 32'h11111111, 1'b0, 1'b1, 32'h34, 32'hCAFEF00D, "after_err");
        req = 2'b00;

        // Move the pointer to 1, then reset while requester 1 is stalled in ACCESS.
        set_slot(0, 1'b1, 32'h40, 32'h44);
        req = 2'b01;
        xfer_check(0, 0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h44, "pre_rst");
        set_slot(0, 1'b0, 32'h50, 32'h0);
        set_slot(1, 1'b1, 32'h300, 32'h33);
        req = 2'b11; PREADY = 1'b0;
        cyc();
        chk("rst_acc_grant1_psel", PSEL, 1'b1);
        chk("rst_acc_grant1_paddr", PADDR, 32'h300);
        cyc();
        chk("rst_acc_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        cyc();
        chk("rst_acc_psel_after", PSEL, 1'b0);
        chk("rst_acc_penable_after", PENABLE, 1'b0);
        chk("rst_acc_noack", ack, 2'b00);
        PRESET = 1'b0;
        xfer_check(0, 0, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h50, 32'h0, "post_rst_r0");
        req = 2'b10;
        xfer_check(1, 0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h33, "post_rst_r1");
        req = 2'b00;

        // Randomized traffic against the round-robin model.
        m_ptr = 0; m_last = 1;
        for (int i = 0; i < NR; i++) begin
            m_pend[i] = 1'b0; m_wr[i] = 1'b0; m_ad[i] = '0; m_wd[i] = '0;
        end
        for (int it = 0; it < 80; it++) begin
            any = 1'b0;
            for (int i = 0; i < NR; i++) any |= m_pend[i];
            if (!any && it < 40) begin
                new_req(int'($urandom_range(0, NR - 1)));
                any = 1'b1;
            end
            if (!any) break;
            drive_req();
            g  = pick();
            nw = int'($urandom_range(0, 3));
            rd = $urandom;
            er = ($urandom_range(0, 3) == 0);
            xfer_check(g, nw, rd, er, m_wr[g], m_ad[g], m_wd[g], $sformatf("rand%0d", it));
            m_pend[g] = 1'b0;
            m_ptr  = (g + 1) % NR;
            m_last = g;
            if (it < 39) begin
                for (int i = 0; i < NR; i++)
                    if (!m_pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
        end
        drive_req();

`ifdef APB_TIMEOUT_EN
        // PREADY on the limit cycle completes normally, then a fully stuck slave aborts.
        set_slot(0, 1'b0, 32'h60, 32'h0);
        req = 2'b01;
        xfer_check(0, 15, 32'h76543210, 1'b0, 1'b0, 32'h60, 32'h0, "to_edge");
        complete(0, 1000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h60, 32'h0, "to_abort",
                 en_cnt, ackv, rdv, erv, bus_ok);
        chk("to_abort_enable_cycles", en_cnt, 16);
        chk("to_abort_ack", ackv, 2'b01);
        chk("to_abort_err", erv, 1'b1);
        chk("to_abort_rdata", rdv, 32'h0);
        chk("to_abort_bus_fields", bus_ok, 1'b1);
        req = 2'b00;
`else
        // Stuck slave without the timeout: ACCESS must persist indefinitely.
        set_slot(0, 1'b0, 32'h60, 32'h0);
        req = 2'b01; PREADY = 1'b0;
        cnt = 0; ackseen = 1'b0;
        for (int c = 0; c < 130; c++) begin
            cyc();
            if (PENABLE === 1'b1) cnt++;
            if (ack !== 2'b00) ackseen = 1'b1;
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
        end
        chk("noto_penable_ge100", (cnt >= 100), 1'b1);
        chk("noto_no_ack", ackseen, 1'b0);
        PRESET = 1'b1;
        cyc();
        PRESET = 1'b0; req = 2'b00;
        cyc();
        chk("noto_reset_psel", PSEL, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB bus between NUM_REQ local requesters.
- Accepts simple req/ack transfer requests and sequences IDLE -> SETUP -> ACCESS on PSEL/PENABLE.
- Honours PREADY wait states and returns PRDATA/PSLVERR to the granted requester.
- Sits between internal engines and the APB peripheral fabric.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 16, ACCESS wait limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  clock, all logic on rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- req  input  NUM_REQ  per-requester transfer request, held until ack.
- req_write  input  NUM_REQ  1=write, 0=read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- ack  output  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  output  DATA_WIDTH  read data, valid with ack.
- rsp_err  output  1  PSLVERR (or timeout) status, valid with ack.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Reset: one clock; PRESET is synchronous and active-high. While PRESET is high, on each edge:
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack, rsp_rdata, rsp_err are all 0.
  - FSM goes to IDLE.
  - RR pointer is set to 0, so requester 0 has highest priority.
- All outputs are registered.
- FSM IDLE:
  - PSEL=0, PENABLE=0.
  - Eligible = req & ~ack, so the requester currently being acked is masked.
  - If any requester is eligible: grant the first set bit searching from pointer upward with wrap; latch its write/addr/wdata into PWRITE/PADDR/PWDATA; next state SETUP.
- FSM SETUP:
  - PSEL=1, PENABLE=0, exactly one cycle.
  - Next state ACCESS.
- FSM ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS; all APB outputs stable.
  - PREADY=1: capture PRDATA into rsp_rdata and PSLVERR into rsp_err; assert ack[grant] for the next cycle; pointer = (grant+1) mod NUM_REQ; next state IDLE.
- Latency:
  - req sampled in IDLE at edge T gives PSEL=1 after T, PENABLE=1 after T+1.
  - With PREADY=1 on the first ACCESS cycle, ack is seen after T+2.
  - Minimum 3 cycles per transfer; one IDLE cycle always separates transfers.
- PADDR, PWRITE, PWDATA are held from SETUP through the end of ACCESS and keep their last values in IDLE.
- rsp_rdata is updated on read completions and is 0 for writes.
- PSLVERR and PRDATA are ignored unless PSEL & PENABLE & PREADY.
- Requester contract:
  - Drop req, or present a new request, in the cycle ack is seen.
  - Changing req_* inputs after grant has no effect.
- Simultaneous requests are resolved strictly round-robin. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-transfer: PSEL and PENABLE are 0 after the edge, no ack is issued, and the transfer is lost.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS while PREADY=0 and clears on entering ACCESS.
  - When the count reaches TIMEOUT_CYCLES, abort: next state IDLE, PSEL=PENABLE=0, ack[grant] pulses with rsp_err=1 and rsp_rdata=0, and the pointer advances.
  - PREADY=1 on the same cycle as the limit completes normally.
- Undefined: ACCESS waits indefinitely, no counter logic is built, and TIMEOUT_CYCLES is unused.

Test Plan:
- Write, zero wait: req[0]=1, addr 0x10, wdata 0xA5A50001, PREADY=1.
  - PSEL rises one cycle after req, PENABLE one cycle later, PADDR=0x10 throughout.
  - ack[0] pulses after the ACCESS cycle with rsp_err=0.
- Read, 2 wait states: req[1] read of 0x24, PREADY low for 2 ACCESS cycles, PRDATA=0xDEADBEEF.
  - PENABLE is high for 3 cycles.
  - ack[1] pulses with rsp_rdata=0xDEADBEEF.
- Arbitration: req=2'b11 held continuously from reset, PREADY=1.
  - Grant order is 0,1,0,1.
  - Each transfer takes 3 cycles.
  - ack is never high for two requesters at once.
- Slave error: PSLVERR=1 together with PREADY=1 → rsp_err=1 with ack.
  - A following good transfer returns rsp_err=0.
- Reset in ACCESS: assert PRESET while PENABLE=1 and PREADY=0.
  - PSEL=PENABLE=0 after the edge, no ack.
  - First grant after reset goes to requester 0.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16), PREADY stuck at 0:
  - Abort after 16 ACCESS cycles with ack, rsp_err=1, rsp_rdata=0.
  - Without the macro, the same stimulus keeps PENABLE high for at least 100 cycles.
